// File: rtl/adc_spi_pkg.sv
`default_nettype none
//==============================================================================
// Module   : adc_spi_pkg
// Brief    : Shared constants and types for the LTC2308-style ADC responder.
// Revision : 1.0 - initial release
//==============================================================================
package adc_spi_pkg;

    // Default result and config widths of the emulated converter
    localparam int DEF_DATA_W = 12;
    localparam int DEF_CFG_W  = 6;

    // Bit positions inside the 6-bit config word (first bit shifted in is S/D)
    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    // Responder frame state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FETCH = 2'd2
    } adc_state_t;

endpackage : adc_spi_pkg
`default_nettype wire

// File: rtl/adc_spi_sync_edge.sv
`default_nettype none
//==============================================================================
// Module   : adc_spi_sync_edge
// Brief    : N-stage input synchronizer with single-cycle rise/fall pulses.
// Revision : 1.0 - initial release
//==============================================================================
module adc_spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    generate
        if (STAGES == 1) begin : g_single
            // Single flop capture of the asynchronous pin
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= RST_VAL;
                end else begin
                    r_sync <= i_d;
                end
            end
        end else begin : g_chain
            // Shift the asynchronous pin through the synchronizer chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= {STAGES{RST_VAL}};
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], i_d};
                end
            end
        end
    endgenerate

    // Delayed copy of the synchronized level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= RST_VAL;
        end else begin
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule : adc_spi_sync_edge
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
//==============================================================================
// Module   : adc_spi_responder
// Brief    : Emulates the 4-wire serial port of an LTC2308-style ADC. Decodes
//            the config word, requests samples upstream and returns the
//            previous frame's conversion result MSB first.
// Revision : 1.0 - initial release
//==============================================================================
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CFG_W       = DEF_CFG_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_din,
    output logic              spi_dout,
    output logic              sample_req,
    output logic [2:0]        sample_ch,
    output logic              sample_diff,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_ack,
    output logic [CFG_W-1:0]  cfg_word,
    output logic              cfg_valid,
    output logic              frame_err
);

    localparam int               CNT_W      = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_cnt_cfg  = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] c_cnt_data = CNT_W'(DATA_W);

    // Synchronized pin events
    logic w_cs_rise, w_cs_fall;
    logic w_sclk_rise, w_sclk_fall;
    logic w_din;
    logic w_cs_level_unused, w_sclk_level_unused;
    logic w_din_rise_unused, w_din_fall_unused;

    // cs_n resets to "low" so a frame already in progress at reset release
    // produces no falling edge and is ignored until cs_n cycles high again.
    adc_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_d     (spi_cs_n),
        .o_level (w_cs_level_unused),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    adc_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_d     (spi_sclk),
        .o_level (w_sclk_level_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    adc_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_d     (spi_din),
        .o_level (w_din),
        .o_rise  (w_din_rise_unused),
        .o_fall  (w_din_fall_unused)
    );

    // Registered state
    adc_state_t        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [CFG_W-1:0]  r_cfg_sh;
    logic [DATA_W-1:0] r_result;
    logic              r_dout;
    logic [CFG_W-1:0]  r_cfg_word;
    logic              r_cfg_valid;
    logic              r_frame_err;
    logic              r_req;
    logic [2:0]        r_ch;
    logic              r_diff;

    // Next-state values
    adc_state_t        w_state_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CFG_W-1:0]  w_cfg_sh_nxt;
    logic [DATA_W-1:0] w_result_nxt;
    logic              w_dout_nxt;
    logic [CFG_W-1:0]  w_cfg_word_nxt;
    logic              w_cfg_valid_nxt;
    logic              w_frame_err_nxt;
    logic              w_req_nxt;
    logic [2:0]        w_ch_nxt;
    logic              w_diff_nxt;
    logic              w_start;
    logic [DATA_W-1:0] w_start_val;

    // Frame state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath decode
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_cfg_sh_nxt    = r_cfg_sh;
        w_result_nxt    = r_result;
        w_dout_nxt      = r_dout;
        w_cfg_word_nxt  = r_cfg_word;
        w_cfg_valid_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_req_nxt       = r_req;
        w_ch_nxt        = r_ch;
        w_diff_nxt      = r_diff;
        w_start         = 1'b0;
        w_start_val     = r_result;

        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_start = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_dout_nxt = 1'b0;
                    if (r_cnt >= c_cnt_cfg) begin
                        w_cfg_word_nxt  = r_cfg_sh;
                        w_cfg_valid_nxt = 1'b1;
                        w_ch_nxt        = {r_cfg_sh[CFG_S1], r_cfg_sh[CFG_S0], r_cfg_sh[CFG_OS]};
                        w_diff_nxt      = ~r_cfg_sh[CFG_SD];
                        w_req_nxt       = 1'b1;
                        w_state_nxt     = ST_FETCH;
                    end else begin
                        // Frame ended before a full config word arrived
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = ST_IDLE;
                    end
                end else begin
                    if (w_sclk_rise) begin
                        if (r_cnt < c_cnt_cfg) begin
                            w_cfg_sh_nxt = {r_cfg_sh[CFG_W-2:0], w_din};
                        end
                        if (r_cnt < c_cnt_data) begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                    if (w_sclk_fall) begin
                        if (r_cnt < c_cnt_data) begin
                            w_shift_nxt = r_shift << 1;
                            w_dout_nxt  = r_shift[DATA_W-2];
                        end else begin
                            // All result bits served; idle the line low
                            w_dout_nxt = 1'b0;
                        end
                    end
                end
            end

            ST_FETCH: begin
                if (sample_ack) begin
                    // Ack beats a simultaneous cs_n fall: fresh data is served
                    w_result_nxt = sample_data;
                    w_req_nxt    = 1'b0;
                    if (w_cs_fall) begin
                        w_start     = 1'b1;
                        w_start_val = sample_data;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_cs_fall) begin
                    // Sample never arrived: abandon it and replay the old result
                    w_frame_err_nxt = 1'b1;
                    w_req_nxt       = 1'b0;
                    w_start         = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_start) begin
            w_state_nxt  = ST_SHIFT;
            w_shift_nxt  = w_start_val;
            w_dout_nxt   = w_start_val[DATA_W-1];
            w_cnt_nxt    = '0;
            w_cfg_sh_nxt = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_cfg_sh    <= '0;
            r_result    <= '0;
            r_dout      <= 1'b0;
            r_cfg_word  <= '0;
            r_cfg_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_req       <= 1'b0;
            r_ch        <= 3'd0;
            r_diff      <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cfg_sh    <= w_cfg_sh_nxt;
            r_result    <= w_result_nxt;
            r_dout      <= w_dout_nxt;
            r_cfg_word  <= w_cfg_word_nxt;
            r_cfg_valid <= w_cfg_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_req       <= w_req_nxt;
            r_ch        <= w_ch_nxt;
            r_diff      <= w_diff_nxt;
        end
    end

    assign spi_dout    = r_dout;
    assign sample_req  = r_req;
    assign sample_ch   = r_ch;
    assign sample_diff = r_diff;
    assign cfg_word    = r_cfg_word;
    assign cfg_valid   = r_cfg_valid;
    assign frame_err   = r_frame_err;

endmodule : adc_spi_responder
`default_nettype wire
